// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : valid/ready pipeline stage register with optional 2-entry skid
//            buffer, synchronous flush and saturating bubble/drop counters
// Revision : 1.0
// ============================================================================
module pipe_stage_skid #(
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        SKID       = 1,
  parameter logic [DATA_W-1:0]  RESET_DATA = '0,
  parameter int unsigned        CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  // State encoding doubles as the occupancy count.
  localparam logic [1:0]       c_EMPTY   = 2'd0;
  localparam logic [1:0]       c_ONE     = 2'd1;
  localparam logic [1:0]       c_TWO     = 2'd2;
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_live;
  logic [DATA_W-1:0] r_m_data;
  logic [DATA_W-1:0] w_s_data;
  logic [CNT_W-1:0]  r_bubble;
  logic [CNT_W-1:0]  r_drop;
  logic              w_m_valid;
  logic              w_s_valid;
  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_load_m;
  logic              w_m_from_s;
  logic [1:0]        w_drop_n;
  logic [CNT_W:0]    w_drop_sum;

  assign w_m_valid  = (r_state != c_EMPTY);
  assign w_s_valid  = (r_state == c_TWO);
  assign w_out_fire = w_m_valid && out_ready;
  assign w_in_fire  = in_valid && w_in_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] r_s_data;
      logic              w_load_s;

      // Ready comes from state only, so it never combinationally follows out_ready.
      assign w_in_ready = r_live && reset && !flush && (r_state != c_TWO);
      assign w_load_s   = (r_state == c_ONE) && w_in_fire && !out_ready;
      assign w_s_data   = r_s_data;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_s_data <= RESET_DATA;
        end else if (flush) begin
          r_s_data <= RESET_DATA;
        end else if (w_load_s) begin
          r_s_data <= in_data;
        end
      end
    end else begin : g_pass
      assign w_in_ready = r_live && reset && !flush && (!w_m_valid || out_ready);
      assign w_s_data   = RESET_DATA;
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_load_m    = 1'b0;
    w_m_from_s  = 1'b0;
    if (flush) begin
      w_state_nxt = c_EMPTY;
    end else begin
      case (r_state)
        c_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = c_ONE;
            w_load_m    = 1'b1;
          end
        end
        c_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_load_m = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = c_TWO;
          end else if (w_out_fire) begin
            w_state_nxt = c_EMPTY;
          end
        end
        c_TWO: begin
          if (w_out_fire) begin
            w_state_nxt = c_ONE;
            w_m_from_s  = 1'b1;
          end
        end
        default: w_state_nxt = c_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= c_EMPTY;
      r_live   <= 1'b0;
      r_m_data <= RESET_DATA;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      if (flush) begin
        r_m_data <= RESET_DATA;
      end else if (w_load_m) begin
        r_m_data <= in_data;
      end else if (w_m_from_s) begin
        r_m_data <= w_s_data;
      end
    end
  end

  // Entries lost to a flush; a word consumed in the flush cycle is not a drop.
  assign w_drop_n   = {1'b0, w_m_valid} + {1'b0, w_s_valid} - {1'b0, w_out_fire};
  assign w_drop_sum = {1'b0, r_drop} + {{(CNT_W-1){1'b0}}, w_drop_n};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bubble <= '0;
      r_drop   <= '0;
    end else begin
      if (out_ready && !w_m_valid && (r_bubble != c_CNT_MAX)) begin
        r_bubble <= r_bubble + 1'b1;
      end
      if (flush) begin
        r_drop <= (w_drop_sum > {1'b0, c_CNT_MAX}) ? c_CNT_MAX : w_drop_sum[CNT_W-1:0];
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = w_m_valid;
  assign out_data   = r_m_data;
  assign occupancy  = r_state;
  assign bubble_cnt = r_bubble;
  assign drop_cnt   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Purpose  : scoreboard bench for pipe_stage_skid (skid and pass-through builds)
// Revision : 1.0
// ============================================================================
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: SKID=1, 32-bit payload, RESET_DATA=0, 16-bit counters
  logic        a_rst_n = 1'b0, a_flush = 1'b0, a_iv = 1'b0, a_or = 1'b0;
  logic [31:0] a_id = '0;
  logic        a_ir, a_ov;
  logic [31:0] a_od;
  logic [1:0]  a_occ;
  logic [15:0] a_bub, a_drop;

  // Instance B: SKID=0, 8-bit payload, RESET_DATA=0x5A, 2-bit counters
  logic        b_rst_n = 1'b0, b_flush = 1'b0, b_iv = 1'b0, b_or = 1'b0;
  logic [7:0]  b_id = '0;
  logic        b_ir, b_ov;
  logic [7:0]  b_od;
  logic [1:0]  b_occ;
  logic [1:0]  b_bub, b_drop;

  pipe_stage_skid #(.DATA_W(32), .SKID(1), .RESET_DATA(32'h0), .CNT_W(16)) u_dut_a (
    .clock(clk), .reset(a_rst_n), .flush(a_flush),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .occupancy(a_occ), .bubble_cnt(a_bub), .drop_cnt(a_drop)
  );

  pipe_stage_skid #(.DATA_W(8), .SKID(0), .RESET_DATA(8'h5A), .CNT_W(2)) u_dut_b (
    .clock(clk), .reset(b_rst_n), .flush(b_flush),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .occupancy(b_occ), .bubble_cnt(b_bub), .drop_cnt(b_drop)
  );

  logic [31:0] qa[$];
  logic [7:0]  qb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitors: a handshake that will complete at the next edge pops the queue.
  always @(negedge clk) begin
    if (a_rst_n && a_ov && a_or) begin
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL a_unexpected_word actual=%h required=none", a_od);
      end else begin
        logic [31:0] e;
        e = qa.pop_front();
        if (a_od !== e) begin
          bad++;
          $display("FAIL a_word actual=%h required=%h", a_od, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_rst_n && b_ov && b_or) begin
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL b_unexpected_word actual=%h required=none", b_od);
      end else begin
        logic [7:0] e;
        e = qb.pop_front();
        if (b_od !== e) begin
          bad++;
          $display("FAIL b_word actual=%h required=%h", b_od, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  logic [1:0] drop_exp [4] = '{2'd1, 2'd2, 2'd3, 2'd3};

  initial begin
    // ---------------- A: reset and streaming ----------------
    step(); step(); step();
    chk("a_reset_ov", a_ov, 0);
    chk("a_reset_od", a_od, 32'h0);
    chk("a_reset_ir", a_ir, 0);
    chk("a_reset_occ", a_occ, 0);
    chk("a_reset_bub", a_bub, 0);
    a_rst_n = 1'b1;
    #1;
    chk("a_ir_before_edge", a_ir, 0);
    step();
    chk("a_ir_after_edge", a_ir, 1);

    a_iv = 1'b1; a_or = 1'b1; a_id = 32'h11; qa.push_back(32'h11);
    step();
    chk("a_stream_od1", a_od, 32'h11);
    a_id = 32'h22; qa.push_back(32'h22);
    step();
    chk("a_stream_od2", a_od, 32'h22);
    a_id = 32'h33; qa.push_back(32'h33);
    step();
    chk("a_stream_od3", a_od, 32'h33);
    chk("a_stream_occ", a_occ, 1);
    chk("a_stream_bub", a_bub, 1);
    a_iv = 1'b0;
    step();
    a_or = 1'b0;
    chk("a_drain_occ", a_occ, 0);
    chk("a_drain_bub", a_bub, 1);

    // ---------------- A: skid fill ----------------
    a_iv = 1'b1; a_id = 32'hA; qa.push_back(32'hA);
    step();
    a_id = 32'hB; qa.push_back(32'hB);
    step();
    a_iv = 1'b0;
    chk("a_skid_occ", a_occ, 2);
    chk("a_skid_ir", a_ir, 0);
    chk("a_skid_od", a_od, 32'hA);
    step();
    chk("a_skid_hold_od", a_od, 32'hA);
    chk("a_skid_hold_ov", a_ov, 1);
    a_or = 1'b1;
    step();
    chk("a_skid_pop_od", a_od, 32'hB);
    chk("a_skid_pop_occ", a_occ, 1);
    step();
    a_or = 1'b0;
    chk("a_skid_empty_occ", a_occ, 0);

    // ---------------- A: flush with drops ----------------
    a_iv = 1'b1; a_id = 32'hA;
    step();
    a_id = 32'hB;
    step();
    chk("a_flush_pre_occ", a_occ, 2);
    a_flush = 1'b1; a_id = 32'hC;
    #1;
    chk("a_flush_ir", a_ir, 0);
    step();
    a_flush = 1'b0; a_iv = 1'b0;
    chk("a_flush_occ", a_occ, 0);
    chk("a_flush_ov", a_ov, 0);
    chk("a_flush_drop", a_drop, 2);
    chk("a_flush_od", a_od, 32'h0);
    a_or = 1'b1;
    step(); step();
    a_or = 1'b0;
    chk("a_flush_no_c", a_ov, 0);
    chk("a_flush_bub", a_bub, 3);

    // ---------------- A: flush with consumption ----------------
    a_iv = 1'b1; a_id = 32'hD; qa.push_back(32'hD);
    step();
    a_iv = 1'b0; a_flush = 1'b1; a_or = 1'b1;
    step();
    a_flush = 1'b0; a_or = 1'b0;
    chk("a_fcons_drop", a_drop, 2);
    chk("a_fcons_occ", a_occ, 0);
    chk("a_fcons_bub", a_bub, 3);

    // ---------------- A: asynchronous reset with two entries ----------------
    a_iv = 1'b1; a_id = 32'h1;
    step();
    a_id = 32'h2;
    step();
    a_iv = 1'b0;
    chk("a_arst_pre_occ", a_occ, 2);
    #2;
    a_rst_n = 1'b0;
    #1;
    chk("a_arst_ov", a_ov, 0);
    chk("a_arst_occ", a_occ, 0);
    chk("a_arst_od", a_od, 32'h0);
    chk("a_arst_ir", a_ir, 0);
    chk("a_arst_bub", a_bub, 0);
    chk("a_arst_drop", a_drop, 0);
    step();

    // ---------------- B: pass-through build ----------------
    chk("b_reset_od", b_od, 8'h5A);
    chk("b_reset_ir", b_ir, 0);
    b_rst_n = 1'b1;
    step();
    chk("b_ir_empty", b_ir, 1);
    b_iv = 1'b1; b_id = 8'h05; qb.push_back(8'h05);
    step();
    chk("b_hold_od", b_od, 8'h05);
    b_id = 8'h06;
    #1;
    chk("b_stall_ir", b_ir, 0);
    step();
    chk("b_stall_od", b_od, 8'h05);
    chk("b_stall_occ", b_occ, 1);
    b_or = 1'b1;
    #1;
    chk("b_pass_ir", b_ir, 1);
    qb.push_back(8'h06);
    step();
    chk("b_pass_od", b_od, 8'h06);
    chk("b_pass_occ", b_occ, 1);
    b_iv = 1'b0;
    step();
    chk("b_drain_occ", b_occ, 0);
    chk("b_drain_bub", b_bub, 0);
    for (int i = 0; i < 6; i++) step();
    chk("b_bub_sat", b_bub, 3);
    b_or = 1'b0;

    // Drop counter saturates at 3 across repeated single-entry flushes.
    for (int i = 0; i < 4; i++) begin
      b_iv = 1'b1; b_id = 8'hE0 + 8'(i);
      step();
      b_iv = 1'b0; b_flush = 1'b1;
      step();
      b_flush = 1'b0;
      chk("b_drop_sat", b_drop, drop_exp[i]);
      chk("b_flush_od", b_od, 8'h5A);
    end
    chk("b_bub_final", b_bub, 3);

    step(); step();
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
